// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory boot loader.
// Holds the loader FSM states, the RX bit-index constants and the default baud divisor.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_DONE
    } loader_state_e;

    localparam logic [3:0] RX_BIT_START = 4'd0;
    localparam logic [3:0] RX_BIT_STOP  = 4'd9;

    // 50 MHz / 115200 baud
    localparam int unsigned DEFAULT_BAUD_DIV = 434;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling and false-start rejection.
// Emits one-cycle rx_valid with rx_byte on a good stop bit, or rx_ferr on a bad one.
module uart_rx_core
    import imem_loader_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

    logic             sync1;
    logic             sync2;
    logic             rxd_prev;
    logic             busy;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            rxd_prev  <= 1'b1;
            busy      <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            rx_ferr   <= 1'b0;
        end else begin
            sync1    <= rxd;
            sync2    <= sync1;
            rxd_prev <= sync2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;

            if (!busy) begin
                if (rxd_prev && !sync2) begin
                    busy     <= 1'b1;
                    baud_cnt <= HALF_M1;
                    bit_idx  <= RX_BIT_START;
                end
            end else if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - CNT_W'(1);
            end else begin
                // Sample point: half a bit after the edge, then once per bit.
                baud_cnt <= FULL_M1;
                bit_idx  <= bit_idx + 4'd1;
                if (bit_idx == RX_BIT_START) begin
                    if (sync2) begin
                        busy <= 1'b0;
                    end
                end else if (bit_idx == RX_BIT_STOP) begin
                    busy <= 1'b0;
                    if (sync2) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= shift_reg;
                    end else begin
                        rx_ferr <= 1'b1;
                    end
                end else begin
                    shift_reg <= {sync2, shift_reg[7:1]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed little-endian word image over UART and writes
// it into the instruction RAM while holding the CPU in reset.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned BAUD_DIV        = DEFAULT_BAUD_DIV,
    parameter int unsigned IMEM_ADDR_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_imem,
    input  logic                       uart_rxd,
    output logic                       imem_wr_en,
    output logic [IMEM_ADDR_WIDTH-3:0] imem_wr_addr,
    output logic [31:0]                imem_wr_data,
    output logic                       cpu_hold,
    output logic                       load_done,
    output logic                       load_error
);

    localparam int unsigned WA_W = IMEM_ADDR_WIDTH - 2;

    logic            rx_valid;
    logic [7:0]      rx_byte;
    logic            rx_ferr;

    loader_state_e   state;
    logic            load_q;
    logic            load_rise;
    logic [15:0]     word_cnt;
    logic [WA_W-1:0] word_addr;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_reg;

    uart_rx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rxd     (uart_rxd),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .rx_ferr (rx_ferr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            load_q       <= 1'b0;
            load_rise    <= 1'b0;
            word_cnt     <= '0;
            word_addr    <= '0;
            byte_cnt     <= '0;
            word_reg     <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            load_q     <= load_imem;
            load_rise  <= load_imem & ~load_q;
            imem_wr_en <= 1'b0;
            // Status outputs trail the state by one cycle, so cpu_hold drops with load_done.
            load_done  <= (state == ST_DONE);
            cpu_hold   <= (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_DATA);

            if (state != ST_IDLE && !load_imem) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_rise) begin
                            load_error <= 1'b0;
                            word_addr  <= '0;
                            byte_cnt   <= '0;
                            state      <= ST_LEN0;
                        end
                    end
                    ST_LEN0: begin
                        if (rx_ferr) begin
                            load_error <= 1'b1;
                            state      <= ST_IDLE;
                        end else if (rx_valid) begin
                            word_cnt[7:0] <= rx_byte;
                            state         <= ST_LEN1;
                        end
                    end
                    ST_LEN1: begin
                        if (rx_ferr) begin
                            load_error <= 1'b1;
                            state      <= ST_IDLE;
                        end else if (rx_valid) begin
                            word_cnt[15:8] <= rx_byte;
                            state <= ({rx_byte, word_cnt[7:0]} == 16'd0) ? ST_DONE : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (rx_ferr) begin
                            load_error <= 1'b1;
                            state      <= ST_IDLE;
                        end else if (rx_valid) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            case (byte_cnt)
                                2'd0: word_reg[7:0]   <= rx_byte;
                                2'd1: word_reg[15:8]  <= rx_byte;
                                2'd2: word_reg[23:16] <= rx_byte;
                                default: begin
                                    imem_wr_en   <= 1'b1;
                                    imem_wr_addr <= word_addr;
                                    imem_wr_data <= {rx_byte, word_reg};
                                    word_addr    <= word_addr + WA_W'(1);
                                    word_cnt     <= word_cnt - 16'd1;
                                    if (word_cnt == 16'd1) begin
                                        state <= ST_DONE;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
